bus_rx8: RTL
============

BUS_RX8 -- requirements
Module: bus_rx8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data byte width.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port bus_din  input  WIDTH  byte driven by upstream 8-bit bus buffer.
REQ-006 SHALL have port bus_we  input  1  write strobe; bus_din is valid in the same cycle.
REQ-007 SHALL have port bus_ack  output  1  registered, one-cycle pulse per accepted byte.
REQ-008 SHALL have port full  output  1  combinational from count; high when count == DEPTH.
REQ-009 SHALL have port dout  output  WIDTH  head-of-FIFO byte, first-word fall-through.
REQ-010 SHALL have port dout_valid  output  1  high when count != 0.
REQ-011 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid is high.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 SHALL have port overflow  output  1  sticky flag marking a dropped byte.
REQ-014 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-015 Push SHALL occur when bus_we is high and either full is low or a pop occurs in the same cycle.
REQ-016 Pop SHALL occur when dout_valid is high and dout_ready is high.
REQ-017 On a push, bus_din SHALL be written at wr_ptr, and wr_ptr SHALL increment modulo DEPTH.
REQ-018 On a pop, rd_ptr SHALL increment modulo DEPTH.
REQ-019 count SHALL change as follows: +1 on push only; -1 on pop only; unchanged on push+pop or on neither.
REQ-020 Latency SHALL be one cycle: a byte pushed at edge N appears on dout with dout_valid high after edge N when the FIFO was empty.
REQ-021 dout SHALL equal the mem[rd_ptr] value when dout_valid is high, and SHALL be all-zero when the FIFO is empty.
REQ-022 bus_ack SHALL be high in the cycle after each push and low otherwise; back-to-back pushes give a continuous high.
REQ-023 When bus_we is high, full is high and no pop occurs, the byte SHALL be dropped, state SHALL be left unchanged, and overflow SHALL be set on the next edge.
REQ-024 overflow SHALL clear on ovf_clr; if ovf_clr and a new drop occur in the same cycle, overflow SHALL remain set.
REQ-025 Simultaneous push and pop on a full FIFO SHALL be accepted without overflow, leaving count == DEPTH.
REQ-026 Pointer wrap-around SHALL be transparent; ordering SHALL be strict FIFO across the wrap.

Reset
REQ-027 While rst is high, the following SHALL hold at 0 regardless of clk: wr_ptr, rd_ptr, count, bus_ack, overflow. Consequently dout_valid, full and dout are also 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all buffered bytes; the first push after deassertion SHALL land at entry 0.

Structure
REQ-030 WIDTH/DEPTH defaults and the pointer-width function SHALL reside in the shared package bus_pkg, reused by the upstream buffer side.
REQ-031 Storage SHALL be one sub-module, rx_mem, a DEPTHxWIDTH register array with one write port and one asynchronous read port. Pointer, count and flag logic SHALL stay in bus_rx8.

Verification
REQ-032 Reset, then push 8'hA5 with dout_ready=0: bus_ack pulses once, dout=8'hA5, dout_valid=1, count=1.
REQ-033 Push 8'h01..8'h04 then a fifth byte 8'h05 with dout_ready=0: full=1, 8'h05 dropped, overflow=1, count=4; pop all four gives 01,02,03,04.
REQ-034 Full FIFO, bus_we=1 with 8'h55 and dout_ready=1 in the same cycle: head popped, 8'h55 stored last, count=4, overflow stays 0.
REQ-035 Stream 10 bytes 8'h10..8'h19 with dout_ready=1 every cycle: output order matches across pointer wrap, count never exceeds 1, bus_ack high for 10 consecutive cycles.
REQ-036 With 3 bytes stored and overflow=1, assert rst asynchronously between edges: count, dout_valid, overflow and bus_ack go to 0 immediately; the next push of 8'hC3 reads back as 8'hC3.
REQ-037 With overflow=1, assert ovf_clr together with a new drop: overflow stays 1; assert ovf_clr alone: overflow goes to 0.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared byte-bus defaults and pointer-width helper
//   WIDTH_DEF - default data byte width
//   DEPTH_DEF - default FIFO depth (power of two, 2..16)
//   ptr_w()   - bits needed to address DEPTH entries
package bus_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  function automatic int ptr_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/bus_rx8_rx_mem.sv
// rx_mem: DEPTHxWIDTH register array, one write port, one async read port
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read data
module rx_mem import bus_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/bus_rx8.sv
// bus_rx8: first-word-fall-through receive FIFO for an 8-bit bus with ack and sticky overflow
//   clk, rst            - clock, async active-high reset
//   bus_din, bus_we     - upstream byte and write strobe
//   bus_ack             - registered pulse per accepted byte
//   full, count         - occupancy status
//   dout, dout_valid    - head byte (zero when empty) and its valid
//   dout_ready          - consumer accept
//   overflow, ovf_clr   - sticky dropped-byte flag and its sync clear
module bus_rx8 import bus_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        bus_din,
  input  logic                    bus_we,
  output logic                    bus_ack,
  output logic                    full,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [ptr_w(DEPTH):0]   count,
  output logic                    overflow,
  input  logic                    ovf_clr
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic ack_q, ack_d, ovf_q, ovf_d, push, pop;
  logic [WIDTH-1:0] rdata;
  assign full       = count_q == CW'(DEPTH);
  assign dout_valid = count_q != '0;
  assign dout       = dout_valid ? rdata : '0;
  assign count      = count_q;
  assign bus_ack    = ack_q;
  assign overflow   = ovf_q;
  // a pop frees the slot in the same cycle, so a full FIFO still accepts a push
  always_comb begin
    pop     = dout_valid && dout_ready;
    push    = bus_we && (!full || pop);
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    count_d = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
    ack_d   = push;
    // a fresh drop wins over a simultaneous clear
    ovf_d   = (bus_we && !push) || (ovf_q && !ovf_clr);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ack_q   <= ack_d;
      ovf_q   <= ovf_d;
    end
  rx_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_q),
    .wdata (bus_din),
    .raddr (rd_q),
    .rdata (rdata)
  );
endmodule
